fetch_unit: RTL and testbench

Instruction-fetch stage between the instruction memory and the decode stage of the pipelined RV32I core. Owns the program counter, issues single-outstanding read requests to the instruction memory, and buffers returned instructions with their PCs in a small FIFO. Presents them to decode over a valid/ready handshake. Branch/jump redirects flush the FIFO and discard any in-flight response.

---
 rtl/fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding reads and buffers {pc, instr} for decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        instruction_mem_request,
    output logic        instruction_mem_we_re,
    output logic [3:0]  instruc_mask_singal,
    output logic [31:0] pc_address,
    input  logic        instruc_mem_valid,
    input  logic [31:0] instruction,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0] DEPTH_M1 = (PTR_W + 1)'(BUF_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       drain_pc_q, drain_pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [31:0]       buf_instr_q [BUF_DEPTH];
    logic [31:0]       buf_pc_q    [BUF_DEPTH];

    logic              fifo_valid;
    logic              push;
    logic              pop;
    logic              flush;
    logic              bypass;
    logic [PTR_W:0]    pop_ext;
    logic [31:0]       redirect_pc_al;

    assign instruction_mem_request = (state_q == REQ);
    assign instruction_mem_we_re   = 1'b0;
    assign instruc_mask_singal     = 4'b1111;
    assign pc_address              = pc_q;

    assign redirect_pc_al = redirect_pc & ~32'h3;
    assign fifo_valid     = (count_q != '0);
    assign pop            = fifo_valid & id_ready;
    assign pop_ext        = {{PTR_W{1'b0}}, pop};

    // Responses are only consumed in WAIT and DRAIN; anything arriving elsewhere is stale.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drain_pc_d = drain_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        bypass     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) begin
                    pc_d  = redirect_pc_al;
                    flush = 1'b1;
                end
            end
            REQ: begin
                state_d = WAIT;
                if (redirect) begin
                    state_d    = DRAIN;
                    drain_pc_d = redirect_pc_al;
                    flush      = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    flush = 1'b1;
                    if (instruc_mem_valid) begin
                        pc_d    = redirect_pc_al;
                        state_d = REQ;
                    end else begin
                        drain_pc_d = redirect_pc_al;
                        state_d    = DRAIN;
                    end
                end else if (instruc_mem_valid) begin
                    pc_d = pc_q + 32'd4;
`ifdef FETCH_BYPASS_EN
                    bypass = (count_q == '0) && id_ready;
`else
                    bypass = 1'b0;
`endif
                    push    = ~bypass;
                    // Refetch only if a slot remains free once this entry lands.
                    state_d = (bypass || ((count_q - pop_ext) < DEPTH_M1)) ? REQ : HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc_al;
                    flush   = 1'b1;
                    state_d = REQ;
                end else if (pop) begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    drain_pc_d = redirect_pc_al;
                    flush      = 1'b1;
                end
                if (instruc_mem_valid) begin
                    pc_d    = redirect ? redirect_pc_al : drain_pc_q;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + {{PTR_W{1'b0}}, push} - pop_ext;
        end
    end

    always_comb begin
        id_valid       = fifo_valid;
        id_instruction = fifo_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
        id_pc          = fifo_valid ? buf_pc_q[rd_ptr_q]    : 32'h0;
`ifdef FETCH_BYPASS_EN
        if (bypass) begin
            id_valid       = 1'b1;
            id_instruction = instruction;
            id_pc          = pc_q;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            drain_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drain_pc_q <= drain_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: buffer storage is not reset; count_q gates every read, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= instruction;
            buf_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable memory responder, directed sequences
// and a table of {latency, expected request PC, expected decode word} vectors.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instruction_mem_request;
    logic        instruction_mem_we_re;
    logic [3:0]  instruc_mask_singal;
    logic [31:0] pc_address;
    logic        instruc_mem_valid = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic        id_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    bit fixed_data = 1'b1;
    int acc_cnt = 0;
    int req_cnt = 0;

    fetch_unit dut (
        .clk                     (clk),
        .rst                     (rst),
        .instruction_mem_request (instruction_mem_request),
        .instruction_mem_we_re   (instruction_mem_we_re),
        .instruc_mask_singal     (instruc_mask_singal),
        .pc_address              (pc_address),
        .instruc_mem_valid       (instruc_mem_valid),
        .instruction             (instruction),
        .redirect                (redirect),
        .redirect_pc             (redirect_pc),
        .id_valid                (id_valid),
        .id_instruction          (id_instruction),
        .id_pc                   (id_pc),
        .id_ready                (id_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return fixed_data ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
    endfunction

    // Memory responder: one response, mem_lat cycles after the request cycle.
    initial begin
        bit          pend;
        int          cnt;
        logic [31:0] pend_addr;
        pend = 1'b0;
        cnt = 0;
        pend_addr = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            instruc_mem_valid = 1'b0;
            if (!rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("pc_stable_while_pending", pc_address, pend_addr);
                    cnt--;
                    if (cnt == 0) begin
                        instruc_mem_valid = 1'b1;
                        instruction = mem_word(pend_addr);
                        pend = 1'b0;
                    end
                end
                if (instruction_mem_request) begin
                    check("single_outstanding", {31'h0, pend}, 32'h0);
                    pend = 1'b1;
                    pend_addr = pc_address;
                    cnt = mem_lat;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst && id_valid && id_ready) acc_cnt++;
        if (rst && instruction_mem_request) req_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic nstep(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        int          lat;
        logic [31:0] req_pc;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int rc;
        int base;
        int w;

        vecs[0] = '{lat: 1, req_pc: 32'h0000_0000, instr: 32'h0000_FFFF};
        vecs[1] = '{lat: 5, req_pc: 32'h0000_0004, instr: 32'h0004_FFFB};
        vecs[2] = '{lat: 2, req_pc: 32'h0000_0008, instr: 32'h0008_FFF7};
        vecs[3] = '{lat: 4, req_pc: 32'h0000_000C, instr: 32'h000C_FFF3};
        vecs[4] = '{lat: 3, req_pc: 32'h0000_0010, instr: 32'h0010_FFEF};
        vecs[5] = '{lat: 1, req_pc: 32'h0000_0014, instr: 32'h0014_FFEB};

        // Reset values
        nstep(2);
        check("rst_request", {31'h0, instruction_mem_request}, 32'h0);
        check("rst_we_re", {31'h0, instruction_mem_we_re}, 32'h0);
        check("rst_mask", {28'h0, instruc_mask_singal}, 32'hF);
        check("rst_pc", pc_address, 32'h0);
        check("rst_id_valid", {31'h0, id_valid}, 32'h0);
        check("rst_id_instr", id_instruction, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);

        // Basic stream with a 1-cycle memory, then back-pressure into HOLD
        fixed_data = 1'b1;
        mem_lat = 1;
        do_reset();
        nstep(1);
        check("s1_req0", {31'h0, instruction_mem_request}, 32'h1);
        check("s1_req0_pc", pc_address, 32'h0);
        check("s1_idv0", {31'h0, id_valid}, 32'h0);
        nstep(1);
        check("s1_wait_noreq", {31'h0, instruction_mem_request}, 32'h0);
        check("s1_no_bypass", {31'h0, id_valid}, 32'h0);
        nstep(1);
        check("s1_req1_pc", pc_address, 32'h4);
        check("s1_req1", {31'h0, instruction_mem_request}, 32'h1);
        check("s1_id0_valid", {31'h0, id_valid}, 32'h1);
        check("s1_id0_pc", id_pc, 32'h0);
        check("s1_id0_instr", id_instruction, 32'h13);
        nstep(1);
        check("s1_id_gap", {31'h0, id_valid}, 32'h0);
        nstep(1);
        check("s1_req2_pc", pc_address, 32'h8);
        check("s1_id1_pc", id_pc, 32'h4);
        nstep(2);
        check("s1_id2_pc", id_pc, 32'h8);
        check("s1_req3_pc", pc_address, 32'hC);
        id_ready = 1'b0;
        nstep(1);
        rc = req_cnt;
        nstep(9);
        check("hold_no_requests", req_cnt, rc);
        check("hold_no_req_now", {31'h0, instruction_mem_request}, 32'h0);
        check("hold_head_valid", {31'h0, id_valid}, 32'h1);
        check("hold_head_pc", id_pc, 32'h8);
        id_ready = 1'b1;
        nstep(1);
        check("resume_req", {31'h0, instruction_mem_request}, 32'h1);
        check("resume_req_pc", pc_address, 32'h10);
        check("resume_second_entry", id_pc, 32'hC);
        nstep(1);
        check("resume_drained", {31'h0, id_valid}, 32'h0);
        nstep(1);
        check("resume_next_pc", id_pc, 32'h10);
        check("resume_next_req_pc", pc_address, 32'h14);

        // Redirect in WAIT without valid: flush, drain the stale response, refetch aligned
        fixed_data = 1'b0;
        mem_lat = 3;
        do_reset();
        nstep(2);
        check("rw_wait", {31'h0, instruction_mem_request}, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        nstep(1);
        redirect = 1'b0;
        check("rw_pc_held", pc_address, 32'h0);
        check("rw_flushed", {31'h0, id_valid}, 32'h0);
        nstep(1);
        check("rw_drained_no_id", {31'h0, id_valid}, 32'h0);
        nstep(1);
        check("rw_new_req", {31'h0, instruction_mem_request}, 32'h1);
        check("rw_new_req_pc", pc_address, 32'h100);
        nstep(3);
        check("rw_not_yet", {31'h0, id_valid}, 32'h0);
        nstep(1);
        check("rw_id_valid", {31'h0, id_valid}, 32'h1);
        check("rw_id_pc", id_pc, 32'h100);
        check("rw_id_instr", id_instruction, 32'h0100_FEFF);

        // Second redirect while draining overwrites the stored PC
        do_reset();
        nstep(2);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        nstep(1);
        redirect_pc = 32'h0000_0208;
        nstep(1);
        redirect = 1'b0;
        nstep(1);
        check("rd_overwrite_req", {31'h0, instruction_mem_request}, 32'h1);
        check("rd_overwrite_pc", pc_address, 32'h208);

        // Redirect during REQ goes through DRAIN
        mem_lat = 2;
        do_reset();
        nstep(1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0080;
        nstep(1);
        redirect = 1'b0;
        check("rq_pc_held", pc_address, 32'h0);
        nstep(2);
        check("rq_new_req", {31'h0, instruction_mem_request}, 32'h1);
        check("rq_new_req_pc", pc_address, 32'h80);

        // Redirect in the same cycle as valid: data discarded, refetch next cycle
        mem_lat = 1;
        do_reset();
        nstep(2);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0040;
        nstep(1);
        redirect = 1'b0;
        check("rv_req", {31'h0, instruction_mem_request}, 32'h1);
        check("rv_req_pc", pc_address, 32'h40);
        check("rv_discarded", {31'h0, id_valid}, 32'h0);
        nstep(1);
        check("rv_discarded2", {31'h0, id_valid}, 32'h0);
        nstep(1);
        check("rv_id_pc", id_pc, 32'h40);
        check("rv_id_instr", id_instruction, 32'h0040_FFBF);

        // PC wrap at the top of the address space
        do_reset();
        nstep(2);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        nstep(1);
        redirect = 1'b0;
        check("wrap_req_pc", pc_address, 32'hFFFF_FFFC);
        nstep(2);
        check("wrap_next_req", {31'h0, instruction_mem_request}, 32'h1);
        check("wrap_next_pc", pc_address, 32'h0);
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_id_instr", id_instruction, 32'hFFFC_0003);

        // Table-driven variable latency
        mem_lat = vecs[0].lat;
        do_reset();
        base = acc_cnt;
        for (int i = 0; i < 6; i++) begin
            w = 0;
            while (!instruction_mem_request && w < 20) begin
                @(negedge clk);
                w++;
            end
            check($sformatf("tbl%0d_req_seen", i), {31'h0, instruction_mem_request}, 32'h1);
            check($sformatf("tbl%0d_req_pc", i), pc_address, vecs[i].req_pc);
            if (i + 1 < 6) mem_lat = vecs[i + 1].lat;
            w = 0;
            @(negedge clk);
            while (!id_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
            check($sformatf("tbl%0d_id_valid", i), {31'h0, id_valid}, 32'h1);
            check($sformatf("tbl%0d_id_pc", i), id_pc, vecs[i].req_pc);
            check($sformatf("tbl%0d_id_instr", i), id_instruction, vecs[i].instr);
        end
        nstep(1);
        check("tbl_accept_count", acc_cnt - base, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
